uart_ctrl: RTL

//  Memory-mapped controller sitting between the RV32I core's native memory bus and the AXI4-Stream uart.

---
 rtl/uart_ctrl_pkg.sv | 45 ++++
 rtl/uart_ctrl_fifo.sv | 73 +++++++
 rtl/uart_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl shared definitions: register offsets, STATUS/IRQ_EN bit indices,
// FSM state encodings and a small saturation helper. Imported by RTL and bench.
package uart_ctrl_pkg;

  // register index (mem_addr[3:2]) and byte offsets
  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_PRESCALE = 2'd2;
  localparam logic [1:0] REG_IRQ_EN   = 2'd3;

  localparam logic [3:0] OFS_DATA     = 4'h0;
  localparam logic [3:0] OFS_STATUS   = 4'h4;
  localparam logic [3:0] OFS_PRESCALE = 4'h8;
  localparam logic [3:0] OFS_IRQ_EN   = 4'hC;

  // STATUS bit indices
  localparam int ST_TX_EMPTY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_RX_BUSY   = 5;
  localparam int ST_OVERRUN   = 6;
  localparam int ST_FRAME     = 7;
  localparam int ST_RXCNT_LSB = 8;

  // IRQ_EN bit indices
  localparam int IRQ_RX  = 0;
  localparam int IRQ_TX  = 1;
  localparam int IRQ_ERR = 2;

  // bus FSM
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_STALL  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // clamp a count into the 8-bit rx_count field
  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/uart_ctrl_fifo.sv
// uart_ctrl_fifo: synchronous FIFO with a registered head word.
// o_head always holds the oldest entry, so a consumer can pop every cycle
// without a read bubble. Push while full / pop while empty are ignored.
module uart_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_head;
  logic             w_push, w_pop;
  logic [AW-1:0]    w_rd_nxt;

  assign w_pop    = i_pop  && (r_cnt != '0);
  assign w_push   = i_push && (r_cnt != CW'(DEPTH));
  assign w_rd_nxt = r_rd + 1'b1;

  // storage write
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // head register: next-oldest entry on pop, bypass of write data when the
  // incoming word becomes the oldest
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (w_pop) begin
      if (r_cnt > CW'(1))  r_head <= r_mem[w_rd_nxt];
      else if (w_push)     r_head <= i_wdata;
    end else if (w_push && (r_cnt == '0)) begin
      r_head <= i_wdata;
    end
  end

  assign o_head  = r_head;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped bridge between the core bus and an AXI-Stream uart.
// TX/RX byte FIFOs, prescale register, sticky error flags.
// Optional feature macro: UART_CTRL_IRQ_EN adds the IRQ_EN register and irq output.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH     = 8,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [15:0] PRESCALE_RESET = 16'd54
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic                  mem_sel,
  input  logic [3:0]            mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  tx_busy,
  input  logic                  rx_busy,
  input  logic                  rx_overrun_error,
  input  logic                  rx_frame_error,
  output logic [15:0]           prescale
`ifdef UART_CTRL_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_rdata, w_rdata;
  logic [15:0]           r_prescale;
  logic                  r_ovr, r_frm;
  logic                  w_tx_push, w_rx_pop, w_ld_rdata, w_wr_presc;
  logic                  w_w1c_ovr, w_w1c_frm, w_wr_irqen;
  logic [1:0]            w_reg;
  logic                  w_wr;
  logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [CW-1:0]         w_tx_cnt, w_rx_cnt;
  logic [DATA_WIDTH-1:0] w_rx_head;
  logic                  w_unused;

  assign w_reg = mem_addr[3:2];
  assign w_wr  = |mem_wstrb;   // any strobe means a full-word write

  uart_ctrl_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_wdata (mem_wdata[DATA_WIDTH-1:0]),
    .i_pop   (m_axis_tvalid & m_axis_tready),
    .o_head  (m_axis_tdata),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_cnt)
  );

  uart_ctrl_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (s_axis_tvalid & s_axis_tready),
    .i_wdata (s_axis_tdata),
    .i_pop   (w_rx_pop),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_cnt)
  );

  assign m_axis_tvalid = !w_tx_empty;
  assign s_axis_tready = !w_rx_full;   // a byte arriving while full is the uart's overrun

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and per-access strobes
  always_comb begin
    w_state_nxt = r_state;
    w_tx_push   = 1'b0;
    w_rx_pop    = 1'b0;
    w_ld_rdata  = 1'b0;
    w_wr_presc  = 1'b0;
    w_w1c_ovr   = 1'b0;
    w_w1c_frm   = 1'b0;
    w_wr_irqen  = 1'b0;
    case (r_state)
      S_IDLE: if (mem_valid && mem_sel) w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        w_state_nxt = S_RESP;
        w_ld_rdata  = 1'b1;
        if (w_wr) begin
          case (w_reg)
            REG_DATA: begin
              if (w_tx_full) w_state_nxt = S_STALL;
              else           w_tx_push   = 1'b1;
            end
            REG_STATUS: begin
              w_w1c_ovr = mem_wdata[ST_OVERRUN];
              w_w1c_frm = mem_wdata[ST_FRAME];
            end
            REG_PRESCALE: w_wr_presc = 1'b1;
            REG_IRQ_EN:   w_wr_irqen = 1'b1;
          endcase
        end else if (w_reg == REG_DATA) begin
          w_rx_pop = !w_rx_empty;
        end
      end
      // wait for the uart to free a TX slot, then complete the push
      S_STALL: begin
        if (!w_tx_full) begin
          w_tx_push   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      // master drops mem_valid after ready, so valid is not re-sampled here
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef UART_CTRL_IRQ_EN
  logic [2:0] r_irq_en;
  logic       r_irq;

  // IRQ_EN register and registered interrupt line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_irqen) r_irq_en <= mem_wdata[2:0];
      r_irq <= (r_irq_en[IRQ_RX]  & !w_rx_empty) |
               (r_irq_en[IRQ_TX]  &  w_tx_empty) |
               (r_irq_en[IRQ_ERR] & (r_ovr | r_frm));
    end
  end

  assign irq = r_irq;
`endif

  // read data mux
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_DATA: begin
        if (!w_rx_empty) begin
          w_rdata[DATA_WIDTH-1:0] = w_rx_head;
          w_rdata[31]             = 1'b1;
        end
      end
      REG_STATUS: begin
        w_rdata[ST_TX_EMPTY]          = w_tx_empty;
        w_rdata[ST_TX_FULL]           = w_tx_full;
        w_rdata[ST_RX_EMPTY]          = w_rx_empty;
        w_rdata[ST_RX_FULL]           = w_rx_full;
        w_rdata[ST_TX_BUSY]           = tx_busy;
        w_rdata[ST_RX_BUSY]           = rx_busy;
        w_rdata[ST_OVERRUN]           = r_ovr;
        w_rdata[ST_FRAME]             = r_frm;
        w_rdata[ST_RXCNT_LSB +: 8]    = sat8(32'(w_rx_cnt));
      end
      REG_PRESCALE: w_rdata[15:0] = r_prescale;
      REG_IRQ_EN: begin
`ifdef UART_CTRL_IRQ_EN
        w_rdata[2:0] = r_irq_en;
`endif
      end
    endcase
  end

  // response data, prescale and sticky error flags (a set beats a same-cycle clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata    <= '0;
      r_prescale <= PRESCALE_RESET;
      r_ovr      <= 1'b0;
      r_frm      <= 1'b0;
    end else begin
      if (w_ld_rdata) r_rdata    <= w_wr ? 32'd0 : w_rdata;
      if (w_wr_presc) r_prescale <= mem_wdata[15:0];
      r_ovr <= rx_overrun_error | (r_ovr & ~w_w1c_ovr);
      r_frm <= rx_frame_error   | (r_frm & ~w_w1c_frm);
    end
  end

  assign mem_ready = (r_state == S_RESP);
  assign mem_rdata = r_rdata;
  assign prescale  = r_prescale;

  // address low bits, high write-data bits and TX count are intentionally unused
  assign w_unused = ^{mem_addr[1:0], mem_wdata, w_tx_cnt, w_wr_irqen};

endmodule
